// File: rtl/calc_seq.sv
// calc_seq: command sequencer and accumulator owner for the calculator datapath.
//
// Debounces the up/down pushbuttons, queues up to DEPTH {enc_op, sw} commands,
// and on an up-press replays the queue through the external combinational ALU,
// one command every STEP_CYCLES cycles, writing each result into the 16-bit
// accumulator that drives the LEDs.
//
// Ports:
//   clk, rst      system clock; synchronous active-high reset
//   btnu          raw button: start replay / abort replay / clear accumulator
//   btnd          raw button: enqueue {enc_op, sw}
//   sw[15:0]      operand, two's complement
//   enc_op[3:0]   ALU op from the button encoder
//   alu_res[31:0] ALU result, combinational from alu_op/op_a/op_b
//   alu_op[3:0]   op presented to the ALU (head entry in RUN, enc_op in IDLE)
//   op_a[31:0]    sign-extended accumulator
//   op_b[31:0]    sign-extended operand (head entry in RUN, sw in IDLE)
//   led[15:0]     accumulator value
//   busy          high while replaying (RUN state)
//   full, empty   queue status
//   count         number of queued entries
//
// Handshake note: there is no valid/ready interface here; the only "events"
// are the one-cycle debounced pulses, and each pulse is consumed on the single
// edge that follows it.
module calc_seq #(
    parameter int DB_CYCLES   = 4,
    parameter int DEPTH       = 4,
    parameter int STEP_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btnu,
    input  logic                     btnd,
    input  logic [15:0]              sw,
    input  logic [3:0]               enc_op,
    input  logic [31:0]              alu_res,
    output logic [3:0]               alu_op,
    output logic [31:0]              op_a,
    output logic [31:0]              op_b,
    output logic [15:0]              led,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int SCW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning. Index 1 = btnu, index 0 = btnd.
    // ------------------------------------------------------------------
    logic [1:0]     w_btn;
    logic [1:0]     r_sync;
    logic [1:0]     r_db;
    logic [1:0]     r_db_d;
    logic [1:0]     r_pulse;
    logic [DBW-1:0] r_db_cnt [2];
    logic           w_pu;
    logic           w_pd;

    assign w_btn = {btnu, btnd};
    assign w_pu  = r_pulse[1];
    assign w_pd  = r_pulse[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            r_pulse <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= w_btn[i];
                if (r_sync[i] != r_db[i]) begin
                    // The edge that would bring the count to DB_CYCLES is the
                    // accepting edge; the counter clears instead of storing it.
                    if (r_db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
                        r_db[i]     <= r_sync[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
                r_db_d[i]  <= r_db[i];
                // Rising edge of the debounced level only; release is silent.
                r_pulse[i] <= r_db[i] & ~r_db_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Command queue storage and status
    // ------------------------------------------------------------------
    logic [19:0]    r_mem [DEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;
    logic [19:0]    w_head_entry;
    logic           w_full;
    logic           w_empty;

    assign w_head_entry = r_mem[r_head];
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_empty      = (r_count == '0);

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_nxt;
    logic [SCW-1:0] r_step;
    logic [SCW-1:0] w_step_nxt;
    logic [15:0]    r_acc;
    logic [15:0]    w_acc_nxt;
    logic           w_acc_we;
    logic           w_push;
    logic           w_pop;
    logic           w_flush;
    logic [15:0]    w_alu_hi_unused;

    // Only the low half of the ALU result is kept in the accumulator.
    assign w_alu_hi_unused = alu_res[31:16];

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_acc_nxt   = r_acc;
        w_acc_we    = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_step_nxt = '0;
                // pu has priority; a simultaneous pd is discarded.
                if (w_pu) begin
                    if (!w_empty) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_acc_we  = 1'b1;
                        w_acc_nxt = '0;
                    end
                end else if (w_pd && !w_full) begin
                    w_push = 1'b1;
                end
            end
            S_RUN: begin
                // Abort wins over a step write landing on the same edge.
                if (w_pu) begin
                    w_flush     = 1'b1;
                    w_step_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_step == SCW'(STEP_CYCLES - 1)) begin
                    w_acc_we   = 1'b1;
                    w_acc_nxt  = alu_res[15:0];
                    w_pop      = 1'b1;
                    w_step_nxt = '0;
                    if (r_count == CW'(1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_step_nxt = r_step + SCW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_acc   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            if (w_acc_we) begin
                r_acc <= w_acc_nxt;
            end
            if (w_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                // Push happens only in IDLE and pop only in RUN, so they
                // never coincide.
                if (w_push) begin
                    r_tail  <= (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + PW'(1);
                    r_count <= r_count + CW'(1);
                end
                if (w_pop) begin
                    r_head  <= (r_head == PW'(DEPTH - 1)) ? '0 : r_head + PW'(1);
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    // Entry storage needs no reset; an entry is only read after it is written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= {enc_op, sw};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_op = (r_state == S_RUN) ? w_head_entry[19:16] : enc_op;
    assign op_b   = (r_state == S_RUN) ? {{16{w_head_entry[15]}}, w_head_entry[15:0]}
                                       : {{16{sw[15]}}, sw};
    assign op_a   = {{16{r_acc[15]}}, r_acc};
    assign led    = r_acc;
    assign busy   = (r_state == S_RUN);
    assign full   = w_full;
    assign empty  = w_empty;
    assign count  = r_count;

endmodule

// File: tb/tb_calc_seq.sv
// Testbench for calc_seq: table-driven vectors, hand-written multi-cycle
// sequences and a randomized command mix checked against a queue-based model.
module tb_calc_seq;

  localparam int DB_CYCLES   = 4;
  localparam int DEPTH       = 4;
  localparam int STEP_CYCLES = 8;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        btnu;
  logic        btnd;
  logic [15:0] sw;
  logic [3:0]  enc_op;
  logic [31:0] alu_res;
  logic [3:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [15:0] led;
  logic        busy;
  logic        full;
  logic        empty;
  logic [2:0]  count;

  always #5 clk = ~clk;

  calc_seq #(
    .DB_CYCLES   (DB_CYCLES),
    .DEPTH       (DEPTH),
    .STEP_CYCLES (STEP_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btnu    (btnu),
    .btnd    (btnd),
    .sw      (sw),
    .enc_op  (enc_op),
    .alu_res (alu_res),
    .alu_op  (alu_op),
    .op_a    (op_a),
    .op_b    (op_b),
    .led     (led),
    .busy    (busy),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Bench ALU: add 0010, sub 0110, and 0000, or 0001, xor 0011.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0011: return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_res = alu_f(alu_op, op_a, op_b);

  // ---------------- scoreboard ----------------
  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] exp_q[$];
  logic [19:0] cmd_q[$];
  logic [15:0] model_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One replay step as the model sees it: acc op sext(sw), low 16 bits kept.
  function automatic logic [15:0] model_step(input logic [15:0] acc, input logic [19:0] cmd);
    logic [31:0] r;
    r = alu_f(cmd[19:16], {{16{acc[15]}}, acc}, {{16{cmd[15]}}, cmd[15:0]});
    return r[15:0];
  endfunction

  // ---------------- driver tasks ----------------
  // Clean press held 8 cycles then released with 10 quiet cycles; the action
  // lands 6 edges after the first high sample, well inside the window.
  task automatic press(input logic up, input logic dn, input logic [3:0] op,
                       input logic [15:0] v);
    enc_op = op;
    sw     = v;
    btnu   = up;
    btnd   = dn;
    repeat (8) @(negedge clk);
    btnu = 1'b0;
    btnd = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Start a replay with btnu and check every step against exp_q.
  task automatic do_replay(input logic [15:0] acc0);
    int          n;
    logic [15:0] prev;
    logic [15:0] e;
    n    = exp_q.size();
    prev = acc0;
    btnu = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) check("busy_before_entry", busy, 0);
      if (k == 7) check("busy_at_entry", busy, 1);
    end
    btnu = 1'b0;
    for (int i = 1; i <= n * STEP_CYCLES; i++) begin
      @(negedge clk);
      if (i % STEP_CYCLES == STEP_CYCLES - 1) check("led_hold", led, prev);
      if (i % STEP_CYCLES == 0) begin
        e = exp_q.pop_front();
        check("led_step", led, e);
        prev = e;
      end
      if (i == n * STEP_CYCLES - 1) check("busy_last_cycle", busy, 1);
      if (i == n * STEP_CYCLES) begin
        check("busy_fall", busy, 0);
        check("empty_after_run", empty, 1);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [3:0]  op;
    logic [15:0] sw;
    logic [15:0] exp_led;
    logic [31:0] exp_op_b;
  } vec_t;

  vec_t prev_tbl[4];
  vec_t cmd_tbl[8];
  logic [3:0] ops[5];

  initial begin
    // Live preview in IDLE: alu_op = enc_op, op_b = sext(sw).
    prev_tbl[0] = '{4'b0010, 16'h0005, 16'h0000, 32'h0000_0005};
    prev_tbl[1] = '{4'b0110, 16'h8000, 16'h0000, 32'hFFFF_8000};
    prev_tbl[2] = '{4'b1111, 16'h7FFF, 16'h0000, 32'h0000_7FFF};
    prev_tbl[3] = '{4'b0000, 16'hFFFF, 16'h0000, 32'hFFFF_FFFF};
    // Replay 0..2 (acc from 0), full/sign 3..7 (5th is dropped).
    cmd_tbl[0] = '{4'b0010, 16'd5,    16'd5,    32'h0};
    cmd_tbl[1] = '{4'b0010, 16'd3,    16'd8,    32'h0};
    cmd_tbl[2] = '{4'b0110, 16'd2,    16'd6,    32'h0};
    cmd_tbl[3] = '{4'b0010, 16'hFFF6, 16'hFFF6, 32'h0};
    cmd_tbl[4] = '{4'b0010, 16'hFFF6, 16'hFFEC, 32'h0};
    cmd_tbl[5] = '{4'b0010, 16'hFFF6, 16'hFFE2, 32'h0};
    cmd_tbl[6] = '{4'b0010, 16'hFFF6, 16'hFFD8, 32'h0};
    cmd_tbl[7] = '{4'b0010, 16'hFFF6, 16'hFFD8, 32'h0};
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
    ops[3] = 4'b0110; ops[4] = 4'b0011;

    rst = 1'b1; btnu = 1'b0; btnd = 1'b0; sw = '0; enc_op = '0;

    // ---- reset ----
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    enc_op = 4'hA;
    #1;
    check("rst_led", led, 0);
    check("rst_op_a", op_a, 0);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_alu_op", alu_op, 4'hA);
    @(negedge clk);

    // ---- preview table ----
    for (int i = 0; i < 4; i++) begin
      enc_op = prev_tbl[i].op;
      sw     = prev_tbl[i].sw;
      #1;
      check("preview_alu_op", alu_op, prev_tbl[i].op);
      check("preview_op_b", op_b, prev_tbl[i].exp_op_b);
      check("preview_op_a", op_a, 0);
      @(negedge clk);
    end

    // ---- bounce: 2 high, 1 low, 3 high never reaches DB_CYCLES ----
    btnd = 1'b1; repeat (2) @(negedge clk);
    btnd = 1'b0; @(negedge clk);
    btnd = 1'b1; repeat (3) @(negedge clk);
    btnd = 1'b0; repeat (12) @(negedge clk);
    check("bounce_count", count, 0);

    // ---- long hold: exactly one push, 6 edges after first high sample ----
    enc_op = cmd_tbl[0].op;
    sw     = cmd_tbl[0].sw;
    btnd   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 6) check("hold_count_before", count, 0);
      if (k == 7) check("hold_count_at", count, 1);
    end
    btnd = 1'b0;
    repeat (12) @(negedge clk);
    check("hold_count_once", count, 1);

    // ---- replay table ----
    for (int i = 1; i < 3; i++) press(1'b0, 1'b1, cmd_tbl[i].op, cmd_tbl[i].sw);
    check("replay_count", count, 3);
    for (int i = 0; i < 3; i++) exp_q.push_back(cmd_tbl[i].exp_led);
    do_replay(16'd0);
    check("replay_final_led", led, 16'd6);

    // ---- clear with empty queue, then full / sign ----
    press(1'b1, 1'b0, 4'b0000, 16'h0);
    check("clear_led", led, 0);
    for (int i = 3; i < 8; i++) begin
      press(1'b0, 1'b1, cmd_tbl[i].op, cmd_tbl[i].sw);
      check("full_count", count, (i - 2 > DEPTH) ? DEPTH : i - 2);
    end
    check("full_flag", full, 1);
    check("full_empty", empty, 0);
    for (int i = 3; i < 7; i++) exp_q.push_back(cmd_tbl[i].exp_led);
    do_replay(16'd0);
    check("full_final_full", full, 0);

    // ---- abort after first write ----
    press(1'b1, 1'b0, 4'b0000, 16'h0);
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 4'b0010, 16'd1);
    btnu = 1'b1;
    for (int k = 1; k <= 7; k++) @(negedge clk);
    btnu = 1'b0;
    check("abort_busy_in", busy, 1);
    for (int i = 1; i <= 8; i++) @(negedge clk);
    check("abort_first_write", led, 1);
    btnu = 1'b1;
    for (int i = 9; i <= 15; i++) begin
      @(negedge clk);
      if (i == 14) check("abort_busy_before", busy, 1);
    end
    btnu = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_count", count, 0);
    check("abort_empty", empty, 1);
    check("abort_led", led, 1);
    repeat (20) @(negedge clk);
    check("abort_no_second_write", led, 1);
    check("abort_stays_idle", busy, 0);

    // ---- clear, and pu+pd together ----
    press(1'b1, 1'b0, 4'b0000, 16'h0);
    check("clear2_led", led, 0);
    press(1'b0, 1'b1, 4'b0010, 16'd7);
    exp_q.push_back(16'd7);
    do_replay(16'd0);
    press(1'b1, 1'b1, 4'b0010, 16'd9);
    check("both_led", led, 0);
    check("both_count", count, 0);

    // ---- randomized command mix vs queue model ----
    model_acc = 16'd0;
    for (int it = 0; it < 14; it++) begin
      logic [3:0]  rop;
      logic [15:0] rsw;
      logic [15:0] a;
      rop = ops[$urandom_range(0, 4)];
      rsw = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 2) == 0) begin
        if (cmd_q.size() == 0) begin
          press(1'b1, 1'b0, rop, rsw);
          model_acc = 16'd0;
        end else begin
          a = model_acc;
          foreach (cmd_q[j]) begin
            a = model_step(a, cmd_q[j]);
            exp_q.push_back(a);
          end
          do_replay(model_acc);
          model_acc = a;
          cmd_q.delete();
        end
      end else begin
        press(1'b0, 1'b1, rop, rsw);
        if (cmd_q.size() < DEPTH) cmd_q.push_back({rop, rsw});
      end
      check("rnd_count", count, cmd_q.size());
      check("rnd_led", led, model_acc);
      check("rnd_full", full, cmd_q.size() == DEPTH);
    end

    // ---- reset in the middle of RUN ----
    press(1'b0, 1'b1, 4'b0010, 16'd3);
    press(1'b0, 1'b1, 4'b0010, 16'd4);
    btnu = 1'b1;
    repeat (7) @(negedge clk);
    btnu = 1'b0;
    check("midrst_busy_in", busy, 1);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_led", led, 0);
    repeat (10) @(negedge clk);
    check("midrst_stays_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calc_seq.md
# calc_seq

Command sequencer and accumulator owner for the calculator datapath. It debounces the up/down pushbuttons and queues up to DEPTH commands; each command is an ALU op from the button encoder plus a switch operand. It then replays the queue through the shared combinational ALU, one command per step, writing each result into the accumulator shown on the LEDs. It sits between the board I/O and the ALU, which it drives directly.

## Interface
- DB_CYCLES, 4: consecutive cycles a synchronised button level must differ from its debounced level before it is accepted.
- DEPTH, 4: command queue entries; must be a power of 2.
- STEP_CYCLES, 8: cycles spent on each command during replay; must be ≥ 1.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- btnu  in  1  raw pushbutton: start replay, abort replay, or clear the accumulator.
- btnd  in  1  raw pushbutton: enqueue a command.
- sw  in  16  operand, two's complement.
- enc_op  in  4  ALU op from the button encoder.
- alu_res  in  32  ALU result; combinational from alu_op/op_a/op_b.
- alu_op  out  4  op presented to the ALU.
- op_a  out  32  sign-extended accumulator.
- op_b  out  32  sign-extended operand.
- led  out  16  accumulator value.
- busy  out  1  high while in RUN.
- full  out  1  queue holds DEPTH entries.
- empty  out  1  queue holds 0 entries.
- count  out  $clog2(DEPTH)+1  number of queued entries.

## Operation
- Button conditioning, applied separately to btnu and btnd:
  - One synchroniser flop, then the debounce counter.
  - The counter increments on each edge where the synchronised value differs from the debounced value, and clears on any edge where they match.
  - When the counter reaches DB_CYCLES, the debounced value takes the synchronised value and the counter clears.
  - A registered pulse (pu/pd) is high for exactly one cycle after the debounced value goes 0→1.
  - Holding a button produces one pulse. Release produces no pulse.
- Queue: a circular FIFO of {enc_op, sw}, 20 bits per entry, with head and tail pointers that wrap modulo DEPTH.
- Accumulator: 16-bit register `acc`.
  - led = acc.
  - op_a = sign-extension of acc to 32 bits.
- FSM states: IDLE, RUN.
- IDLE, actions on the edge where a pulse is seen:
  - pu with the queue non-empty → RUN, step counter = 0.
  - pu with the queue empty → acc = 0.
  - pd with pu low → push {enc_op, sw}, provided the queue is not full.
  - pd while full: the command is dropped silently and count is unchanged.
  - pu and pd in the same cycle: pu wins and pd is discarded.
- RUN:
  - alu_op and op_b come from the head entry (op_b = sign-extended head sw).
  - The step counter increments each cycle.
  - On the edge where step counter == STEP_CYCLES-1: acc = alu_res[15:0] (upper bits discarded), pop the head, and clear the step counter.
  - If that pop empties the queue, go to IDLE on the same edge.
  - pd in RUN is ignored.
  - pu in RUN aborts: flush the queue (count = 0, pointers equal) and go to IDLE. acc keeps its value. The pending step is not written.
- In IDLE, alu_op = enc_op and op_b = sign-extended sw, giving a live preview. acc does not change except on clear.

## Timing
- Reset values:
  - acc, led = 0; op_a = 0.
  - busy = 0, full = 0, empty = 1, count = 0.
  - State is IDLE. All debounced levels, counters and pulses are 0. Pointers are 0.
  - Reset mid-RUN discards all entries and returns to IDLE on the next edge.
- Press-to-pulse latency:
  - Take edge t as the first edge sampling the button high, with the button held from then on.
  - The debounced level rises at edge t+DB_CYCLES. The pulse is high in the cycle after edge t+DB_CYCLES+1.
  - The action takes effect at the next edge: DB_CYCLES+2 edges after t.
- Queue and status timing:
  - count, full and empty update on the edge of the push, pop or flush.
  - busy rises on the edge that enters RUN.
- Replay timing:
  - N queued entries keep busy high for N·STEP_CYCLES cycles.
  - acc updates every STEP_CYCLES edges, starting STEP_CYCLES edges after RUN entry.
  - The last write and the fall of busy occur on the same edge.
- alu_op, op_a and op_b are combinational from state, head entry, acc and inputs. alu_res is sampled in the same cycle.

## Test plan
- Reset: assert rst 2 cycles → led=0, busy=0, empty=1, full=0, count=0; alu_op follows enc_op.
- Bounce: btnd high 2 cycles, low 1, high 3, low → count stays 0. Then btnd held 20 cycles → count=1 exactly once, entering 6 edges after first high sample (DB_CYCLES=4).
- Replay: the bench ALU model is add on 0010 and sub on 0110. Enqueue (0010,5), (0010,3), (0110,2), then pulse btnu → busy high 24 cycles; led steps 5, 8, 6 at 8-cycle intervals; finally empty=1, busy=0.
- Full/sign: enqueue 5 entries of (0010,16'hFFF6) → 5th dropped, count=4, full=1. Replay from acc=0 → led=FFF6, FFEC, FFE2, FFD8.
- Abort: queue 3 adds of 1, start RUN; pu arrives after the first write → led=1, count=0, busy=0 the next edge; the second write never happens.
- Clear: acc=1, queue empty, pulse btnu → led=0. btnu and btnd pulses together in IDLE with the queue empty → acc=0 and count stays 0.
